// File: rtl/wb_la_mailbox_pkg.sv
// Shared offsets, status bit positions and byte-mask helpers
// for the logic-analyzer / management Wishbone mailbox.
package wb_la_mailbox_pkg;

  localparam logic [1:0] MBX_LA_TX   = 2'd0;
  localparam logic [1:0] MBX_LA_RX   = 2'd1;
  localparam logic [1:0] MBX_LA_STAT = 2'd2;

  localparam logic [7:0] MBX_TX_LO = 8'h00;
  localparam logic [7:0] MBX_TX_HI = 8'h04;
  localparam logic [7:0] MBX_RX_LO = 8'h08;
  localparam logic [7:0] MBX_RX_HI = 8'h0C;
  localparam logic [7:0] MBX_STAT  = 8'h10;

  localparam int LA_ST_TX_FULL  = 0;
  localparam int LA_ST_RX_EMPTY = 1;
  localparam int MB_ST_TX_NE    = 0;
  localparam int MB_ST_RX_FULL  = 1;
  localparam int MB_ST_OVF      = 2;
  localparam int ST_TXCNT       = 8;
  localparam int ST_RXCNT       = 16;

  function automatic logic [31:0] merge32(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mask64(
    input logic [63:0] d,
    input logic [7:0]  sel
  );
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++)
      if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wb_la_mailbox_if.sv
// Bus bundle: management classic Wishbone slave port plus
// the core's pipelined 64-bit logic-analyzer Wishbone master.
interface wb_la_mailbox_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic        wb_la_cyc;
  logic        wb_la_stb;
  logic        wb_la_we;
  logic [31:0] wb_la_adr;
  logic [7:0]  wb_la_sel;
  logic [63:0] wb_la_dat_o;
  logic [63:0] wb_la_dat_i;
  logic        wb_la_ack;
  logic        wb_la_stall;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  wb_la_cyc, wb_la_stb, wb_la_we,
    input  wb_la_adr, wb_la_sel, wb_la_dat_o,
    output wb_la_dat_i, wb_la_ack, wb_la_stall
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output wb_la_cyc, wb_la_stb, wb_la_we,
    output wb_la_adr, wb_la_sel, wb_la_dat_o,
    input  wb_la_dat_i, wb_la_ack, wb_la_stall
  );
endinterface

// File: rtl/mbx_fifo.sv
// Small register-file FIFO; full blocks push even when a pop
// happens in the same cycle. DEPTH must be a power of two.
module mbx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

  // next storage, pointers and occupancy
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d = wptr_q + AW'(1);
    end
    if (do_pop)
      rptr_d = rptr_q + AW'(1);
    if (do_push & ~do_pop)
      count_d = count_q + CW'(1);
    else if (do_pop & ~do_push)
      count_d = count_q - CW'(1);
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_la_mailbox.sv
// Mailbox bridge: core LA master <-> management SoC slave,
// with a TX and an RX FIFO and a TX-nonempty interrupt.
module wb_la_mailbox
  import wb_la_mailbox_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_la_mailbox_if.slave    bus,
  output logic              irq_o
);

  logic [63:0]   tx_dout, rx_dout, tx_din, rx_din;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  logic          la_ack_q, la_ack_d;
  logic [63:0]   la_dat_q, la_dat_d;
  logic          wbs_ack_q, wbs_ack_d;
  logic [31:0]   wbs_dat_q, wbs_dat_d;
  logic [31:0]   lo_q, lo_d, hi_q, hi_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;

  logic          la_stall, la_req, mb_hit;
  logic [1:0]    la_idx;
  logic [7:0]    mb_off;
  logic [63:0]   la_stat;
  logic [31:0]   mb_stat;
  logic          unused_la_adr;

  assign unused_la_adr = ^{bus.wb_la_adr[31:5], bus.wb_la_adr[2:0]};

  assign la_idx   = bus.wb_la_adr[4:3];
  assign la_stall = bus.wb_la_cyc & bus.wb_la_stb & bus.wb_la_we
                  & (la_idx == MBX_LA_TX) & tx_full;
  assign la_req   = bus.wb_la_cyc & bus.wb_la_stb & ~la_stall;
  assign tx_din   = mask64(bus.wb_la_dat_o, bus.wb_la_sel);

  assign mb_off = bus.wbs_adr_i[7:0];
  assign mb_hit = bus.wbs_stb_i & bus.wbs_cyc_i & ~wbs_ack_q
                & (bus.wbs_adr_i[31:8] == ADDR_BASE[31:8]);

  assign bus.wb_la_stall = la_stall;
  assign bus.wb_la_ack   = la_ack_q;
  assign bus.wb_la_dat_i = la_dat_q;
  assign bus.wbs_ack_o   = wbs_ack_q;
  assign bus.wbs_dat_o   = wbs_dat_q;
  assign irq_o           = irq_q;

  // status words seen by each side
  always_comb begin
    la_stat = '0;
    la_stat[LA_ST_TX_FULL]  = tx_full;
    la_stat[LA_ST_RX_EMPTY] = rx_empty;
    la_stat[ST_TXCNT +: 4]  = 4'(tx_count);
    la_stat[ST_RXCNT +: 4]  = 4'(rx_count);
    mb_stat = '0;
    mb_stat[MB_ST_TX_NE]    = ~tx_empty;
    mb_stat[MB_ST_RX_FULL]  = rx_full;
    mb_stat[MB_ST_OVF]      = ovf_q;
    mb_stat[ST_TXCNT +: 4]  = 4'(tx_count);
    mb_stat[ST_RXCNT +: 4]  = 4'(rx_count);
  end

  // core-side decode: TX push, RX pop, registered read data
  always_comb begin
    la_ack_d = la_req;
    la_dat_d = '0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    if (la_req) begin
      if (bus.wb_la_we) begin
        tx_push = (la_idx == MBX_LA_TX);
      end else begin
        unique case (la_idx)
          MBX_LA_RX: begin
            rx_pop   = ~rx_empty;
            la_dat_d = rx_empty ? '0 : rx_dout;
          end
          MBX_LA_STAT: la_dat_d = la_stat;
          default:     la_dat_d = '0;
        endcase
      end
    end
  end

  // mgmt-side decode: TX pop, staging writes, RX push, overflow
  always_comb begin
    wbs_ack_d = mb_hit;
    wbs_dat_d = '0;
    lo_d      = lo_q;
    hi_d      = hi_q;
    ovf_d     = ovf_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    if (mb_hit & ~bus.wbs_we_i) begin
      unique case (mb_off)
        MBX_TX_LO: wbs_dat_d = tx_empty ? '0 : tx_dout[31:0];
        MBX_TX_HI: begin
          wbs_dat_d = tx_empty ? '0 : tx_dout[63:32];
          tx_pop    = ~tx_empty;
        end
        MBX_STAT:  wbs_dat_d = mb_stat;
        default:   wbs_dat_d = '0;
      endcase
    end else if (mb_hit) begin
      unique case (mb_off)
        MBX_RX_LO:
          lo_d = merge32(lo_q, bus.wbs_dat_i, bus.wbs_sel_i);
        MBX_RX_HI: begin
          hi_d = merge32(hi_q, bus.wbs_dat_i, bus.wbs_sel_i);
          if (rx_full) ovf_d   = 1'b1;
          else         rx_push = 1'b1;
        end
        MBX_STAT:
          if (bus.wbs_dat_i[MB_ST_OVF]) ovf_d = 1'b0;
        default: ;
      endcase
    end
    rx_din = {hi_d, lo_q};
    irq_d  = ~tx_empty;
  end

  // bus response, staging and interrupt registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      la_ack_q  <= 1'b0;
      la_dat_q  <= '0;
      wbs_ack_q <= 1'b0;
      wbs_dat_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      la_ack_q  <= la_ack_d;
      la_dat_q  <= la_dat_d;
      wbs_ack_q <= wbs_ack_d;
      wbs_dat_q <= wbs_dat_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  mbx_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_tx (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .push(tx_push), .pop(tx_pop), .din(tx_din),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty),
    .count(tx_count)
  );

  mbx_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_rx (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .push(rx_push), .pop(rx_pop), .din(rx_din),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty),
    .count(rx_count)
  );

endmodule

// File: tb/tb_wb_la_mailbox.sv
// Directed bench for wb_la_mailbox: reset, both data paths,
// TX stall, RX overflow, byte masking and address decode.
module tb_wb_la_mailbox;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   n_chk  = 0;
  int   n_fail = 0;

  wb_la_mailbox_if bus();

  wb_la_mailbox #(.DEPTH(4), .ADDR_BASE(BASE)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: test did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] w(input int i);
    return {32'hAAAA_0000 + 32'(i), 32'h5555_0000 + 32'(i)};
  endfunction

  task automatic la_idle();
    bus.wb_la_cyc   = 1'b0;
    bus.wb_la_stb   = 1'b0;
    bus.wb_la_we    = 1'b0;
    bus.wb_la_adr   = '0;
    bus.wb_la_sel   = '0;
    bus.wb_la_dat_o = '0;
  endtask

  task automatic mb_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
  endtask

  // called at a negedge; returns at the negedge carrying the ack
  task automatic la_xfer(input logic iwe, input logic [1:0] idx,
                         input logic [7:0] sel, input logic [63:0] d,
                         output logic [63:0] rd);
    int n = 0;
    bus.wb_la_cyc   = 1'b1;
    bus.wb_la_stb   = 1'b1;
    bus.wb_la_we    = iwe;
    bus.wb_la_adr   = {27'd0, idx, 3'd0};
    bus.wb_la_sel   = sel;
    bus.wb_la_dat_o = d;
    #1;
    while (bus.wb_la_stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("la_stall_timeout", 64'(bus.wb_la_stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("la_ack", 64'(bus.wb_la_ack), 64'd1);
    rd = bus.wb_la_dat_i;
    la_idle();
  endtask

  task automatic mb_xfer(input logic iwe, input logic [31:0] adr,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic acked);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = iwe;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = d;
    acked = 1'b0;
    rd    = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rd    = bus.wbs_dat_o;
        break;
      end
    end
    mb_idle();
  endtask

  task automatic mb_read(input logic [31:0] adr, output logic [31:0] rd);
    logic a;
    mb_xfer(1'b0, adr, 32'd0, rd, a);
    chk("mb_rd_ack", 64'(a), 64'd1);
  endtask

  task automatic mb_write(input logic [31:0] adr, input logic [31:0] d);
    logic a;
    logic [31:0] rd;
    mb_xfer(1'b1, adr, d, rd, a);
    chk("mb_wr_ack", 64'(a), 64'd1);
  endtask

  initial begin
    logic [63:0] r64;
    logic [31:0] r32, lo, hi;
    logic        ack;

    la_idle();
    mb_idle();
    repeat (3) @(negedge clk);
    chk("rst_irq",     64'(irq),             64'd0);
    chk("rst_la_ack",  64'(bus.wb_la_ack),   64'd0);
    chk("rst_la_dat",  bus.wb_la_dat_i,      64'd0);
    chk("rst_wbs_ack", 64'(bus.wbs_ack_o),   64'd0);
    chk("rst_wbs_dat", 64'(bus.wbs_dat_o),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // TX write accepted, reset right behind it
    bus.wb_la_cyc   = 1'b1;
    bus.wb_la_stb   = 1'b1;
    bus.wb_la_we    = 1'b1;
    bus.wb_la_sel   = 8'hFF;
    bus.wb_la_dat_o = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    #1 rst = 1'b1;
    la_idle();
    @(negedge clk);
    chk("rst_mid_no_ack", 64'(bus.wb_la_ack), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mb_read(BASE + 32'h10, r32);
    chk("rst_mid_mstat", 64'(r32), 64'd0);
    chk("rst_mid_irq", 64'(irq), 64'd0);
    la_xfer(1'b0, 2'd2, 8'h00, 64'd0, r64);
    chk("rst_mid_lastat", r64, 64'h2);

    // core -> mgmt single word
    la_xfer(1'b1, 2'd0, 8'hFF, 64'h1122_3344_5566_7788, r64);
    @(negedge clk);
    chk("c2m_irq_set", 64'(irq), 64'd1);
    mb_read(BASE + 32'h00, r32);
    chk("c2m_lo", 64'(r32), 64'h5566_7788);
    mb_read(BASE + 32'h04, r32);
    chk("c2m_hi", 64'(r32), 64'h1122_3344);
    chk("c2m_irq_hold", 64'(irq), 64'd1);
    @(negedge clk);
    chk("c2m_irq_drop", 64'(irq), 64'd0);

    // five back-to-back TX writes, the fifth stalls
    bus.wb_la_cyc   = 1'b1;
    bus.wb_la_stb   = 1'b1;
    bus.wb_la_we    = 1'b1;
    bus.wb_la_adr   = '0;
    bus.wb_la_sel   = 8'hFF;
    bus.wb_la_dat_o = w(0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("b2b_ack", 64'(bus.wb_la_ack), 64'd1);
      bus.wb_la_dat_o = w(i);
    end
    #1;
    chk("full_stall", 64'(bus.wb_la_stall), 64'd1);
    @(negedge clk);
    chk("full_stall_hold", 64'(bus.wb_la_stall), 64'd1);
    chk("full_no_ack", 64'(bus.wb_la_ack), 64'd0);
    mb_read(BASE + 32'h10, r32);
    chk("full_mstat", 64'(r32), 64'h0000_0401);
    chk("full_stall_st", 64'(bus.wb_la_stall), 64'd1);
    mb_read(BASE + 32'h00, lo);
    mb_read(BASE + 32'h04, hi);
    chk("full_word0", {hi, lo}, w(0));
    chk("full_unstall", 64'(bus.wb_la_stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("full_w4_ack", 64'(bus.wb_la_ack), 64'd1);
    la_idle();
    for (int i = 1; i <= 4; i++) begin
      mb_read(BASE + 32'h00, lo);
      mb_read(BASE + 32'h04, hi);
      chk("full_word", {hi, lo}, w(i));
    end
    @(negedge clk);
    chk("full_irq_drop", 64'(irq), 64'd0);

    // mgmt -> core
    mb_write(BASE + 32'h08, 32'hDEAD_BEEF);
    mb_write(BASE + 32'h0C, 32'hCAFE_F00D);
    la_xfer(1'b0, 2'd1, 8'h00, 64'd0, r64);
    chk("m2c_word", r64, 64'hCAFE_F00D_DEAD_BEEF);
    la_xfer(1'b0, 2'd1, 8'h00, 64'd0, r64);
    chk("m2c_empty_rd", r64, 64'd0);

    // RX overflow
    for (int i = 0; i < 5; i++)
      mb_write(BASE + 32'h0C, 32'h1000 + 32'(i));
    mb_read(BASE + 32'h10, r32);
    chk("ovf_mstat", 64'(r32), 64'h0004_0006);
    la_xfer(1'b0, 2'd2, 8'h00, 64'd0, r64);
    chk("ovf_lastat", r64, 64'h0004_0000);
    mb_write(BASE + 32'h10, 32'h4);
    mb_read(BASE + 32'h10, r32);
    chk("ovf_clear", 64'(r32), 64'h0004_0002);
    for (int i = 0; i < 4; i++) begin
      la_xfer(1'b0, 2'd1, 8'h00, 64'd0, r64);
      chk("ovf_drain", r64, {32'h1000 + 32'(i), 32'hDEAD_BEEF});
    end

    // byte mask on core TX write
    la_xfer(1'b1, 2'd0, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, r64);
    mb_read(BASE + 32'h00, r32);
    chk("mask_lo", 64'(r32), 64'hFFFF_FFFF);
    mb_read(BASE + 32'h04, r32);
    chk("mask_hi", 64'(r32), 64'h0);

    // address decode miss
    mb_xfer(1'b0, 32'h3000_0100, 32'd0, r32, ack);
    chk("miss_rd_ack", 64'(ack), 64'd0);
    mb_xfer(1'b1, 32'h3000_010C, 32'h55, r32, ack);
    chk("miss_wr_ack", 64'(ack), 64'd0);
    mb_read(BASE + 32'h10, r32);
    chk("miss_mstat", 64'(r32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_la_mailbox.md
Name: wb_la_mailbox

Overview:
- Wishbone mailbox bridge: the downstream consumer of the core's 64-bit logic-analyzer Wishbone master (wb_la_*), and a 32-bit slave on the management SoC Wishbone port (wbs_*).
- Two 64-bit FIFOs: TX carries data from the core to management; RX carries data from management to the core.
- Gives firmware on both sides a flow-controlled message channel, plus an interrupt to management.

Parameters:
- DEPTH, 4, entries per FIFO; must be 2, 4 or 8.
- ADDR_BASE, 32'h3000_0000, management-side base; decode compares wbs_adr_i[31:8] to ADDR_BASE[31:8].

Ports:
- wb_clk_i  in  1  single clock for the whole block
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  mgmt classic Wishbone strobe/cycle/write
- wbs_sel_i  in  4  mgmt byte selects
- wbs_adr_i  in  32  mgmt address
- wbs_dat_i  in  32  mgmt write data
- wbs_ack_o  out  1  mgmt acknowledge
- wbs_dat_o  out  32  mgmt read data
- wb_la_cyc, wb_la_stb, wb_la_we  in  1 each  core pipelined Wishbone
- wb_la_adr  in  32  core address; only [4:3] decoded
- wb_la_sel  in  8  core byte selects
- wb_la_dat_o  in  64  core write data
- wb_la_dat_i  out  64  core read data
- wb_la_ack  out  1  core acknowledge
- wb_la_stall  out  1  core stall
- irq_o  out  1  high while TX is non-empty

Behaviour:
- Reset (async, wb_rst_i=1): both FIFOs empty; staging registers, overflow flag, wbs_ack_o, wbs_dat_o, wb_la_ack, wb_la_dat_i and irq_o all 0.
  - Any request accepted before reset gets no ack.
- Core side, pipelined Wishbone:
  - A request is accepted when cyc & stb & !stall.
  - wb_la_ack pulses exactly 1 cycle after acceptance; wb_la_dat_i is registered and valid with the ack.
  - Back-to-back requests are accepted every cycle.
  - wb_la_stall = cyc & stb & we & (adr[4:3]==0) & tx_full; it is combinational and no other case stalls.
- Core map, indexed by adr[4:3]:
  - 0 TX: a write pushes the 64-bit word; bytes not selected by wb_la_sel are stored as 0. A read returns 0.
  - 1 RX: a read pops the RX head and returns it. A read while RX is empty returns 0, does not pop, but is still acked. A write is ignored.
  - 2 STATUS (read): bit0 tx_full, bit1 rx_empty, [11:8] tx_count, [19:16] rx_count.
  - 3: reads 0; writes ignored.
- Mgmt side, classic Wishbone:
  - A hit is stb & cyc & address match & !wbs_ack_o.
  - wbs_ack_o is a 1-cycle pulse, 1 cycle after the hit; wbs_dat_o is registered with the ack.
  - A non-matching address gets no ack and leaves all state unchanged.
- Mgmt map, by offset:
  - 0x00 TX_LO (read): head[31:0]; no pop.
  - 0x04 TX_HI (read): head[63:32]; pops. Reading while TX is empty returns 0 and does not pop.
  - 0x08 RX_LO (write): byte-wise (per wbs_sel_i) update of the lo staging register.
  - 0x0C RX_HI (write): byte-wise update of the hi staging register, then pushes {hi_new, lo} into RX.
    - If RX is full: no push, and the sticky overflow flag sets.
  - 0x10 STATUS: read bit0 tx_nonempty, bit1 rx_full, bit2 overflow, [11:8] tx_count, [19:16] rx_count. Writing 1 to bit2 clears overflow.
  - Other offsets: read 0, writes ignored; all are acked.
- FIFOs:
  - Full blocks a push even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo DEPTH; counts run 0..DEPTH.
  - A pop takes effect on the acking cycle; the next read sees the new head.
- irq_o = registered tx_nonempty; it drops the cycle after the last TX pop.

Decomposition:
- Shared include mailbox_defs.vh holds:
  - core offsets MBX_LA_TX=0, MBX_LA_RX=1, MBX_LA_STAT=2;
  - mgmt offsets MBX_TX_LO=8'h00, MBX_TX_HI=8'h04, MBX_RX_LO=8'h08, MBX_RX_HI=8'h0C, MBX_STAT=8'h10;
  - status bit positions.
- Sub-module mbx_fifo (WIDTH=64, DEPTH), instantiated twice.
  - Ports: push, pop, din, dout (head), full, empty, count.

Test Plan:
- Reset mid-op: core TX write accepted, wb_rst_i=1 the next cycle -> no wb_la_ack; STATUS reads tx_count=0; irq_o=0.
- Core -> mgmt: core writes 64'h1122_3344_5566_7788 with sel=8'hFF -> irq_o=1; mgmt read 0x00=32'h5566_7788; read 0x04=32'h1122_3344; irq_o=0 one cycle later.
- TX full/stall: DEPTH=4, 5 back-to-back core TX writes -> the 5th is held with wb_la_stall=1 until mgmt pops via 0x04; all 5 words then arrive in order.
- Mgmt -> core: write 0x08=32'hDEAD_BEEF, 0x0C=32'hCAFE_F00D -> core RX read returns 64'hCAFE_F00D_DEAD_BEEF; the next RX read returns 0 and is acked.
- Overflow: 5 RX_HI writes with DEPTH=4 -> STATUS bit2=1 and rx_count=4; write 0x10=32'h4 -> bit2=0.
- Byte mask and decode:
  - core TX write with sel=8'h0F of 64'hFFFF_FFFF_FFFF_FFFF -> mgmt reads TX_LO=32'hFFFF_FFFF, then TX_HI=32'h0.
  - mgmt access at 32'h3000_0100 -> no wbs_ack_o.
